// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Brief    : Shared FSM state encoding and hold-counter width for the decoder.
//  Revision : 1.0
// ============================================================================
package decoder_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/hold_counter.sv
`default_nettype none
// ============================================================================
//  Module   : hold_counter
//  Brief    : Loadable down-counter that saturates at zero; flags zero.
//  Revision : 1.0
// ============================================================================
module hold_counter
  import decoder_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule : hold_counter
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_decoder_seq
//  Brief    : Registered binary-to-one-hot decoder with valid/ready input and
//             HOLD_CYC-cycle output hold. Macro DEC_ERR_EN adds the err port.
//  Revision : 1.0
// ============================================================================
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy
`ifdef DEC_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int               c_FULL_W    = 1 << IN_W;
  localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLD_CYC - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   w_out_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_started;
  logic               w_ready;
  logic               w_accept;
  logic               w_load;
  logic               w_cnt_zero;
  logic [OUT_W-1:0]   w_dec;

  // Decode at full 2**IN_W width, then drop lines at and above OUT_W.
  assign w_dec = OUT_W'(c_FULL_W'(1) << in);

`ifdef DEC_ERR_EN
  logic w_oor;

  generate
    if (OUT_W < c_FULL_W) begin : g_oor
      assign w_oor = ({1'b0, in} >= (IN_W + 1)'(OUT_W));
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate
`endif

  hold_counter #(
    .WIDTH (CNT_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .dec      (r_state == ST_HOLD),
    .load_val (c_HOLD_LOAD),
    .zero     (w_cnt_zero)
  );

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
    w_load          = 1'b0;
    w_ready         = 1'b0;

    case (r_state)
      ST_IDLE: w_ready = r_started;
      ST_HOLD: w_ready = w_cnt_zero;
      default: w_ready = 1'b0;
    endcase

    w_accept = in_valid & w_ready;

    if (w_accept) begin
`ifdef DEC_ERR_EN
      if (w_oor) begin
        w_err_nxt       = 1'b1;
        w_out_nxt       = '0;
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end else
`endif
      begin
        w_load          = 1'b1;
        w_out_nxt       = w_dec;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = ST_HOLD;
      end
    end else if ((r_state == ST_HOLD) && w_cnt_zero) begin
      w_out_nxt       = '0;
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign in_ready  = w_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ST_HOLD);

`ifdef DEC_ERR_EN
  assign err = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = r_err;
`endif

endmodule : onehot_decoder_seq
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_decoder_seq
//  Brief    : Directed bench for onehot_decoder_seq across several parameter sets.
//  Revision : 1.0
// ============================================================================
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] din = 3'd0;
  logic       chk_en = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // a: HOLD_CYC=1, b: HOLD_CYC=3, c: HOLD_CYC=2, d: HOLD_CYC=4, e: OUT_W=6
  logic       rdy_a, ov_a, busy_a;  logic [7:0] out_a;
  logic       rdy_b, ov_b, busy_b;  logic [7:0] out_b;
  logic       rdy_c, ov_c, busy_c;  logic [7:0] out_c;
  logic       rdy_d, ov_d, busy_d;  logic [7:0] out_d;
  logic       rdy_e, ov_e, busy_e;  logic [5:0] out_e;
`ifdef DEC_ERR_EN
  logic       err_a, err_b, err_c, err_d, err_e;
`endif

  always #5 clk = ~clk;

  onehot_decoder_seq #(.IN_W(3), .OUT_W(8), .HOLD_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in(din),
    .out(out_a), .out_valid(ov_a), .busy(busy_a)
`ifdef DEC_ERR_EN
    , .err(err_a)
`endif
  );
  onehot_decoder_seq #(.IN_W(3), .OUT_W(8), .HOLD_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in(din),
    .out(out_b), .out_valid(ov_b), .busy(busy_b)
`ifdef DEC_ERR_EN
    , .err(err_b)
`endif
  );
  onehot_decoder_seq #(.IN_W(3), .OUT_W(8), .HOLD_CYC(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in(din),
    .out(out_c), .out_valid(ov_c), .busy(busy_c)
`ifdef DEC_ERR_EN
    , .err(err_c)
`endif
  );
  onehot_decoder_seq #(.IN_W(3), .OUT_W(8), .HOLD_CYC(4)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d), .in(din),
    .out(out_d), .out_valid(ov_d), .busy(busy_d)
`ifdef DEC_ERR_EN
    , .err(err_d)
`endif
  );
  onehot_decoder_seq #(.IN_W(3), .OUT_W(6), .HOLD_CYC(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_e), .in(din),
    .out(out_e), .out_valid(ov_e), .busy(busy_e)
`ifdef DEC_ERR_EN
    , .err(err_e)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot_a", 32'($onehot0(out_a)), 32'd1);
      chk("onehot_b", 32'($onehot0(out_b)), 32'd1);
      chk("onehot_c", 32'($onehot0(out_c)), 32'd1);
      chk("onehot_d", 32'($onehot0(out_d)), 32'd1);
      chk("onehot_e", 32'($onehot0(out_e)), 32'd1);
    end
  end

  typedef struct {
    logic [2:0] idx;
    logic [7:0] exp_out;
  } vec_t;

  vec_t sweep [8];

  initial begin
    sweep[0] = '{3'd0, 8'b0000_0001};
    sweep[1] = '{3'd1, 8'b0000_0010};
    sweep[2] = '{3'd2, 8'b0000_0100};
    sweep[3] = '{3'd3, 8'b0000_1000};
    sweep[4] = '{3'd4, 8'b0001_0000};
    sweep[5] = '{3'd5, 8'b0010_0000};
    sweep[6] = '{3'd6, 8'b0100_0000};
    sweep[7] = '{3'd7, 8'b1000_0000};

    // Reset behaviour
    repeat (2) step();
    chk("rst_out",   32'(out_a),  32'd0);
    chk("rst_valid", 32'(ov_a),   32'd0);
    chk("rst_ready", 32'(rdy_a),  32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(rdy_a), 32'd0);
    step();
    chk("ready_after_edge", 32'(rdy_a), 32'd1);
    chk_en = 1'b1;

    // Sweep, HOLD_CYC=1: one index per cycle, continuous out_valid
    for (int i = 0; i < 8; i++) begin
      din      = sweep[i].idx;
      in_valid = 1'b1;
      step();
      chk($sformatf("sweep_out_%0d", i),   32'(out_a), 32'(sweep[i].exp_out));
      chk($sformatf("sweep_valid_%0d", i), 32'(ov_a),  32'd1);
      chk($sformatf("sweep_ready_%0d", i), 32'(rdy_a), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_end_out",   32'(out_a), 32'd0);
    chk("sweep_end_valid", 32'(ov_a),  32'd0);
    idle(6);

    // Hold, HOLD_CYC=3: in_valid during the first two hold cycles is ignored
    din = 3'd5; in_valid = 1'b1;
    step();
    chk("hold_out0",   32'(out_b),  32'h20);
    chk("hold_ready0", 32'(rdy_b),  32'd0);
    chk("hold_busy0",  32'(busy_b), 32'd1);
    din = 3'd2;
    step();
    chk("hold_out1",   32'(out_b), 32'h20);
    chk("hold_ready1", 32'(rdy_b), 32'd0);
    step();
    chk("hold_out2",   32'(out_b), 32'h20);
    chk("hold_valid2", 32'(ov_b),  32'd1);
    chk("hold_ready2", 32'(rdy_b), 32'd1);
    in_valid = 1'b0;
    step();
    chk("hold_out3",   32'(out_b),  32'd0);
    chk("hold_valid3", 32'(ov_b),   32'd0);
    chk("hold_busy3",  32'(busy_b), 32'd0);
    idle(6);

    // Back-to-back, HOLD_CYC=2: second index waits for the last hold cycle
    din = 3'd1; in_valid = 1'b1;
    step();
    chk("b2b_out0",   32'(out_c), 32'h02);
    chk("b2b_ready0", 32'(rdy_c), 32'd0);
    din = 3'd6;
    step();
    chk("b2b_out1",   32'(out_c), 32'h02);
    chk("b2b_ready1", 32'(rdy_c), 32'd1);
    step();
    chk("b2b_out2",   32'(out_c), 32'h40);
    chk("b2b_valid2", 32'(ov_c),  32'd1);
    in_valid = 1'b0;
    step();
    chk("b2b_out3", 32'(out_c), 32'h40);
    step();
    chk("b2b_out4",   32'(out_c), 32'd0);
    chk("b2b_valid4", 32'(ov_c),  32'd0);
    idle(6);

    // Out-of-range index, OUT_W=6
    din = 3'd5; in_valid = 1'b1;
    step();
    chk("oor_inrange_out", 32'(out_e), 32'h20);
    din = 3'd7;
    step();
    in_valid = 1'b0;
    chk("oor_out", 32'(out_e), 32'd0);
`ifdef DEC_ERR_EN
    chk("oor_err",   32'(err_e), 32'd1);
    chk("oor_valid", 32'(ov_e),  32'd0);
    step();
    chk("oor_err_clear", 32'(err_e), 32'd0);
    chk("oor_ready",     32'(rdy_e), 32'd1);
`else
    chk("oor_valid", 32'(ov_e), 32'd1);
    step();
    chk("oor_valid_clear", 32'(ov_e), 32'd0);
`endif
    idle(6);

    // Async reset mid-HOLD, HOLD_CYC=4
    din = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("arst_out0", 32'(out_d), 32'h08);
    step();
    chk("arst_out1",  32'(out_d),  32'h08);
    chk("arst_busy1", 32'(busy_d), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out",   32'(out_d),  32'd0);
    chk("arst_valid", 32'(ov_d),   32'd0);
    chk("arst_busy",  32'(busy_d), 32'd0);
    chk("arst_ready", 32'(rdy_d),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_release_ready", 32'(rdy_d), 32'd1);
    chk("arst_release_out",   32'(out_d), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_onehot_decoder_seq
`default_nettype wire
